// File: rtl/fifo_pkg.sv
// Types and constants shared by the FIFO read and write controllers.
package fifo_pkg;
    localparam int FIFO_AW    = 10;
    localparam int FWFT_DEPTH = 2;

    // Pointer type for the default-depth FIFO; wrap bit in the MSB.
    typedef logic [FIFO_AW:0] ptr_t;
endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry registered output buffer (head/tail) feeding the FWFT consumer port.
module fifo_out_buf #(
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] head_data,
    output logic          head_valid,
    output logic [1:0]    cnt
);
    logic [DW-1:0] tail_data;
    logic [1:0]    cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (flush)            cnt_nxt = 2'd0;
        else if (push && !pop) cnt_nxt = cnt + 2'd1;
        else if (pop && !push) cnt_nxt = cnt - 2'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_data  <= '0;
            tail_data  <= '0;
            head_valid <= 1'b0;
            cnt        <= 2'd0;
        end else begin
            cnt        <= cnt_nxt;
            head_valid <= (cnt_nxt != 2'd0);
            if (!flush) begin
                if (push && pop) begin
                    // Simultaneous arrival and pop: the arrival goes wherever the
                    // head will be after the pop.
                    if (cnt == 2'd2) begin
                        head_data <= tail_data;
                        tail_data <= push_data;
                    end else begin
                        head_data <= push_data;
                    end
                end else if (push) begin
                    if (cnt == 2'd0) head_data <= push_data;
                    else             tail_data <= push_data;
                end else if (pop && cnt == 2'd2) begin
                    head_data <= tail_data;
                end
            end
        end
    end
endmodule

// File: rtl/fifo_rd_ctrl_fwft.sv
// FIFO read controller for a 1-cycle registered RAM read port, with a 2-deep
// first-word-fall-through output buffer, occupancy count and synchronous flush.
module fifo_rd_ctrl_fwft
    import fifo_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW:0]   i_wptr,
    input  logic [DW-1:0] i_rdata,
    input  logic          i_ready_m,
    input  logic          i_flush,
    input  logic [AW-1:0] i_almostempty_lvl,
    output logic [AW:0]   o_rptr,
    output logic [AW-1:0] o_raddr,
    output logic          o_ren,
    output logic [DW-1:0] o_data_m,
    output logic          o_valid_m,
    output logic [AW+1:0] o_count,
    output logic          o_empty,
    output logic          o_almostempty
);
    logic [AW:0] rptr;
    logic [AW:0] mem_cnt;
    logic        inflight;
    logic [1:0]  buf_cnt;
    logic [1:0]  occ;
    logic        pop;

    assign pop = o_valid_m & i_ready_m;
    assign occ = buf_cnt + {1'b0, inflight};

    // Never request more than the buffer can absorb once in-flight data lands.
    assign o_ren = ~i_flush & (rptr != i_wptr) &
                   ((occ - {1'b0, pop}) < 2'(FWFT_DEPTH));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rptr     <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= o_ren;
            if (i_flush) rptr <= i_wptr;
            else if (o_ren) rptr <= rptr + 1'b1;
        end
    end

    assign o_rptr  = rptr;
    assign o_raddr = rptr[AW-1:0];

    assign mem_cnt       = i_wptr - rptr;
    assign o_count       = {1'b0, mem_cnt} + {{AW{1'b0}}, occ};
    assign o_empty       = (o_count == '0);
    assign o_almostempty = (o_count <= {2'b00, i_almostempty_lvl});

    // Data landing the cycle after a read is always accepted; a flush in that
    // same cycle discards it inside the buffer.
    fifo_out_buf #(.DW(DW)) u_buf (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .push       (inflight),
        .push_data  (i_rdata),
        .pop        (pop),
        .flush      (i_flush),
        .head_data  (o_data_m),
        .head_valid (o_valid_m),
        .cnt        (buf_cnt)
    );
endmodule

// File: tb/tb_fifo_rd_ctrl_fwft.sv
// Scoreboard bench for fifo_rd_ctrl_fwft with a behavioural RAM and write side.
module tb_fifo_rd_ctrl_fwft;
    localparam int AW    = 3;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW:0]   wptr;
    logic [DW-1:0] rdata = '0;
    logic          ready;
    logic          flush;
    logic [AW-1:0] lvl;
    logic [AW:0]   rptr;
    logic [AW-1:0] raddr;
    logic          ren;
    logic [DW-1:0] data_m;
    logic          valid_m;
    logic [AW+1:0] count;
    logic          empty;
    logic          aempty;

    always #5 clk = ~clk;

    fifo_rd_ctrl_fwft #(.AW(AW), .DW(DW)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_wptr            (wptr),
        .i_rdata           (rdata),
        .i_ready_m         (ready),
        .i_flush           (flush),
        .i_almostempty_lvl (lvl),
        .o_rptr            (rptr),
        .o_raddr           (raddr),
        .o_ren             (ren),
        .o_data_m          (data_m),
        .o_valid_m         (valid_m),
        .o_count           (count),
        .o_empty           (empty),
        .o_almostempty     (aempty)
    );

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (ren) rdata <= mem[raddr];

    int            n_cmp = 0, n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] next_val = 16'h0100;
    logic [DW-1:0] held = '0;
    logic          stall_prev = 1'b0;
    int            cyc = 0, hs_cnt = 0, ren_cnt = 0, last_hs_cyc = 0, first_hs_cyc = -1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Write side: one word into RAM, pointer advances, expectation queued.
    task automatic wr();
        mem[wptr[AW-1:0]] = next_val;
        exp_q.push_back(next_val);
        next_val = next_val + 1'b1;
        wptr = wptr + 1'b1;
    endtask

    task automatic drain();
        ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic mon();
        cyc++;
        if (rst_n) begin
            if (ren) ren_cnt++;
            chk("count", count, exp_q.size());
            chk("empty", empty, exp_q.size() == 0);
            chk("almost_empty", aempty, exp_q.size() <= int'(lvl));
            if (stall_prev) begin
                chk("hold_valid", valid_m, 1);
                chk("hold_data", data_m, held);
            end
            if (valid_m && ready) begin
                chk("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("sb_data", data_m, exp_q.pop_front());
                hs_cnt++;
                last_hs_cyc = cyc;
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
            end
            if (flush) exp_q.delete();
            stall_prev = valid_m & ~ready & ~flush;
            held = data_m;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW:0] base;
        logic [AW:0] exp_ptr;
        int          r0, h0, written;

        rst_n = 1'b0; wptr = '0; ready = 1'b0; flush = 1'b0; lvl = 3'd3;
        fork
            forever begin @(negedge clk); mon(); end
        join_none

        // Reset state
        repeat (2) @(posedge clk); #1;
        chk("rst_rptr", rptr, 0);
        chk("rst_valid", valid_m, 0);
        chk("rst_data", data_m, 0);
        chk("rst_ren", ren, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_aempty", aempty, 1);
        rst_n = 1'b1;

        // First word latency: ren in W, valid in W+2
        tick(); wr(); #1;
        chk("w_ren", ren, 1);
        chk("w_count", count, 1);
        tick();
        chk("w1_ren", ren, 0);
        chk("w1_valid", valid_m, 0);
        tick();
        chk("w2_valid", valid_m, 1);
        chk("w2_data", data_m, 16'h0100);
        chk("w2_count", count, 1);
        ready = 1'b1;
        tick();
        chk("w_empty_after", empty, 1);

        // Streaming: 16 back-to-back handshakes
        h0 = hs_cnt; first_hs_cyc = -1;
        for (int i = 0; i < 16; i++) begin tick(); wr(); end
        for (int k = 0; k < 40 && hs_cnt < h0 + 16; k++) tick();
        chk("stream_hs", hs_cnt - h0, 16);
        chk("stream_span", last_hs_cyc - first_hs_cyc, 15);
        tick();
        chk("stream_empty", empty, 1);

        // Backpressure: exactly two reads, then hold
        ready = 1'b0; base = wptr; r0 = ren_cnt;
        for (int i = 0; i < 8; i++) begin tick(); wr(); end
        repeat (4) tick();
        exp_ptr = base + 2'd2;
        chk("bp_ren_pulses", ren_cnt - r0, 2);
        chk("bp_rptr", rptr, exp_ptr);
        chk("bp_count", count, 8);
        chk("bp_valid", valid_m, 1);
        repeat (3) tick();
        chk("bp_ren_idle", ren, 0);
        drain();

        // Wrap-around with random consumer stalls, pointers cross 7->8 and 15->0
        written = 0;
        for (int k = 0; k < 300 && written < 20; k++) begin
            tick();
            ready = 1'($urandom_range(0, 1));
            if (logic'((wptr - rptr) < (AW+1)'(DEPTH))) begin wr(); written++; end
        end
        chk("wrap_written", written, 20);
        drain();
        tick();
        chk("wrap_ptr_eq", rptr, wptr);
        chk("wrap_empty", empty, 1);

        // 4 in RAM + 2 in buffer
        ready = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(); wr(); end
        repeat (4) tick();
        chk("occ6_count", count, 6);
        exp_ptr = wptr - 3'd4;
        chk("occ6_rptr", rptr, exp_ptr);
        drain();

        // Almost-empty sweep, threshold 3
        ready = 1'b0; lvl = 3'd3;
        for (int n = 0; n <= 5; n++) begin
            #1;
            chk("ae_sweep", aempty, n <= 3);
            chk("ae_count", count, n);
            if (n < 5) begin tick(); wr(); end
        end
        drain();

        // Flush with a read in flight
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(); wr(); end
        repeat (3) tick();
        ready = 1'b1;
        tick();
        ready = 1'b0; flush = 1'b1; #1;
        chk("fl_ren_blocked", ren, 0);
        tick();
        flush = 1'b0; #1;
        chk("fl_valid", valid_m, 0);
        chk("fl_rptr", rptr, wptr);
        chk("fl_count", count, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_late_data", valid_m, 0);
        end
        tick(); wr();
        drain();

        tick();
        chk("final_empty", empty, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ctrl_fwft.md
# fifo_rd_ctrl_fwft

Read-side controller for the synchronous FIFO, for memories with a registered (1-cycle) read port. It prefetches words into a 2-entry first-word-fall-through output buffer, so the consumer sees registered data under a valid/ready handshake at full throughput. It adds an occupancy count and a synchronous flush. It sits between the FIFO RAM read port, the write controller (`i_wptr`) and the downstream master.

## Interface
- `AW`, default 10: RAM address width; depth 2^AW.
- `DW`, default 32: data width.
- `i_clk`  in  1: clock.
- `i_rst_n`  in  1: asynchronous, active-low reset.
- `i_wptr`  in  AW+1: write pointer from the write controller, wrap bit in the MSB.
- `i_rdata`  in  DW: RAM read data, valid the cycle after `o_ren`.
- `i_ready_m`  in  1: consumer ready.
- `i_flush`  in  1: synchronous flush; discards all unread data.
- `i_almostempty_lvl`  in  AW: almost-empty threshold.
- `o_rptr`  out  AW+1: read pointer, registered, wrap bit in the MSB.
- `o_raddr`  out  AW: equals `o_rptr[AW-1:0]`.
- `o_ren`  out  1: RAM read enable.
- `o_data_m`  out  DW: head-of-buffer data, registered.
- `o_valid_m`  out  1: `o_data_m` is valid.
- `o_count`  out  AW+2: total words held (RAM + in-flight + buffer).
- `o_empty`  out  1: asserted when `o_count == 0`.
- `o_almostempty`  out  1: asserted when `o_count <= i_almostempty_lvl`.

## Operation
- **Memory occupancy:** `mem_cnt = i_wptr - o_rptr`, computed modulo 2^(AW+1). RAM is non-empty when `o_rptr != i_wptr`.
- **Local occupancy:** `occ = buf_cnt + inflight`, range 0..2. `buf_cnt` (0..2) counts words held in the buffer. `inflight` (0/1) is set in the cycle after `o_ren`.
- **Pop:** `pop = o_valid_m & i_ready_m`.
- **Read enable:** `o_ren = ~i_flush & (o_rptr != i_wptr) & ((occ - pop) < 2)`. `o_ren` is combinational.
- **Pointer update:** `o_rptr` increments by 1 on every `o_ren` and wraps naturally through the MSB.
- **Buffer:** 2-entry FIFO (head/tail). Data arriving on `i_rdata` is written at the tail. Pop removes the head. Arrival and pop in the same cycle with `buf_cnt == 1` moves the arrival to the head.
- **Data hold:** `o_data_m` and `o_valid_m` come directly from head registers. While `o_valid_m` is high and `i_ready_m` is low, `o_data_m` holds stable.
- **No overflow:** the buffer never overflows. The `o_ren` gating guarantees `buf_cnt + inflight <= 2` at all times.
- **Count:** `o_count = mem_cnt + occ`, zero-extended to AW+2 bits. The maximum is 2^AW + 2.
- **Flush (`i_flush = 1` in cycle F):**
  - A handshake in cycle F still completes.
  - At the end of F: `o_rptr <= i_wptr`, buffer cleared, `inflight` cleared.
  - Any `i_rdata` arriving in F+1 from a read issued before F is dropped.
  - In F+1: `o_valid_m = 0`, `o_count` reflects only writes after F, and `o_ren` may assert again.
- **Reset values:**
  - `o_rptr` = 0, `o_raddr` = 0, `o_data_m` = 0, `o_valid_m` = 0.
  - Buffer and `inflight` cleared.
  - With `i_wptr` = 0: `o_ren` = 0, `o_count` = 0, `o_empty` = 1, `o_almostempty` = 1.
- **Reset mid-operation:** all state is lost immediately (asynchronous). The write side must be reset together with this block.

## Timing
- **Issue and delivery:**
  - `o_ren` high in cycle N.
  - `i_rdata` is sampled at the end of N+1.
  - `o_valid_m`/`o_data_m` are valid from cycle N+2.
- **Latency:** `i_wptr` advancing from empty in cycle W gives `o_ren` in W and `o_valid_m` in W+2.
- **Throughput:** sustained one word per cycle with `i_ready_m` held high and the RAM non-empty.
- **Buffer full:** with `i_ready_m` low, at most 2 reads are issued; `o_ren` then stays low until a pop.
- **Pop and refill:**
  - Pop and `o_ren` in the same cycle are allowed when `occ == 2`.
  - `o_count` is unchanged when a pop and a write coincide.
- **Status outputs:** `o_empty`, `o_almostempty` and `o_count` are combinational from registered state and `i_wptr`, with no extra latency.

## Structure
- **Shared package `fifo_pkg`:** holds `ptr_t` (logic [AW:0]) and the localparam `FWFT_DEPTH = 2`. It is shared with the write controller.
- **Sub-module `fifo_out_buf`:** the 2-entry registered buffer. Parameter `DW`; ports: push, push_data, pop, flush, head_data, head_valid, cnt.
- **Top level:** pointer, `inflight`, `o_ren` gating, count and flags.

## Test plan
- **Reset and first word:** after reset, `i_wptr` = 0 → `o_empty` = 1, `o_count` = 0, `o_ren` = 0. Then step `i_wptr` to 1 in cycle W → `o_ren` in W, `o_valid_m` in W+2 with `o_data_m` = RAM[0], `o_count` = 1 throughout.
- **Streaming:** 16 words written, `i_ready_m` = 1 → 16 consecutive handshakes with no gaps after the first, data in order 0..15, ending with `o_empty` = 1.
- **Backpressure:** 8 words written, `i_ready_m` = 0 → exactly 2 `o_ren` pulses, `o_rptr` = 2, `o_count` = 8, `o_data_m` held. Then release → the remaining 6 words arrive in order with no loss.
- **Wrap-around:** AW = 2, push and pop 10 words → `o_rptr` passes 3→4 and 7→0, data correct, `o_empty` correct when `i_wptr` = `o_rptr` in wrapped form. With 4 words in RAM and 2 in the buffer, `o_count` = 6.
- **Flush:** flush while 5 words are pending with one read in flight → next cycle `o_valid_m` = 0, `o_rptr` = `i_wptr`, `o_count` = 0, and the late `i_rdata` is not presented.
- **Almost-empty:** `i_almostempty_lvl` = 3; count swept 0..5 → `o_almostempty` = 1 for counts 0..3 and 0 for 4..5.
